// File: rtl/register_file_2r1w.sv
// Two-read / one-write register file with registered read ports, optional hardwired zero
// register, optional write-to-read forwarding and per-register pending (scoreboard) bits.
module register_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic              readEnableA,
  input  logic [ADDR_W-1:0] readRegA,
  output logic [WIDTH-1:0]  dataOutA,
  output logic              busyA,
  input  logic              readEnableB,
  input  logic [ADDR_W-1:0] readRegB,
  output logic [WIDTH-1:0]  dataOutB,
  output logic              busyB,
  input  logic              reserveEnable,
  input  logic [ADDR_W-1:0] reserveReg,
  output logic              anyBusy
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  // An index is live if it names a real register that is not the hardwired zero.
  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
    idx_ok = ({1'b0, idx} < DEPTH_L) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic             busy_a_q, busy_a_d, busy_b_q, busy_b_d;
  logic             wr_ok_s, rs_ok_s;
  logic [WIDTH-1:0] sel_a_data_s, sel_b_data_s;
  logic             sel_a_busy_s, sel_b_busy_s;

  assign wr_ok_s = writeEnable && idx_ok(writeReg);
  assign rs_ok_s = reserveEnable && idx_ok(reserveReg);

  // Storage next state: a reserve on the same edge as a write leaves the register pending.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (wr_ok_s && (writeReg == i[ADDR_W-1:0])) ? dataIn : regs_q[i];
      pend_d[i] = (rs_ok_s && (reserveReg == i[ADDR_W-1:0])) |
                  (pend_q[i] & ~(wr_ok_s && (writeReg == i[ADDR_W-1:0])));
    end
  end

  // AND-OR read muxes over the pre-edge register and pending state.
  always_comb begin
    sel_a_data_s = '0;
    sel_b_data_s = '0;
    sel_a_busy_s = 1'b0;
    sel_b_busy_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_a_data_s = sel_a_data_s | ({WIDTH{readRegA == i[ADDR_W-1:0]}} & regs_q[i]);
      sel_b_data_s = sel_b_data_s | ({WIDTH{readRegB == i[ADDR_W-1:0]}} & regs_q[i]);
      sel_a_busy_s = sel_a_busy_s | ((readRegA == i[ADDR_W-1:0]) & pend_q[i]);
      sel_b_busy_s = sel_b_busy_s | ((readRegB == i[ADDR_W-1:0]) & pend_q[i]);
    end
  end

  // Port A capture: invalid index reads zero, a matching write is forwarded when enabled.
  always_comb begin
    dout_a_d = dout_a_q;
    busy_a_d = busy_a_q;
    if (!readEnableA) begin
      dout_a_d = dout_a_q;
      busy_a_d = busy_a_q;
    end else if (!idx_ok(readRegA)) begin
      dout_a_d = '0;
      busy_a_d = 1'b0;
    end else if ((BYPASS != 0) && wr_ok_s && (writeReg == readRegA)) begin
      dout_a_d = dataIn;
      busy_a_d = 1'b0;
    end else begin
      dout_a_d = sel_a_data_s;
      busy_a_d = sel_a_busy_s;
    end
  end

  // Port B capture, same rules as port A.
  always_comb begin
    dout_b_d = dout_b_q;
    busy_b_d = busy_b_q;
    if (!readEnableB) begin
      dout_b_d = dout_b_q;
      busy_b_d = busy_b_q;
    end else if (!idx_ok(readRegB)) begin
      dout_b_d = '0;
      busy_b_d = 1'b0;
    end else if ((BYPASS != 0) && wr_ok_s && (writeReg == readRegB)) begin
      dout_b_d = dataIn;
      busy_b_d = 1'b0;
    end else begin
      dout_b_d = sel_b_data_s;
      busy_b_d = sel_b_busy_s;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q   <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q   <= pend_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      busy_a_q <= busy_a_d;
      busy_b_q <= busy_b_d;
    end
  end

  assign dataOutA = dout_a_q;
  assign dataOutB = dout_b_q;
  assign busyA    = busy_a_q;
  assign busyB    = busy_b_q;
  assign anyBusy  = |pend_q;

endmodule
